vending_ctrl_multi: RTL and testbench

//  Parametrised vending controller for NUM_PROD products, each with its own price.

---
 rtl/vending_ctrl_multi.sv | 219 +++++++++++++++++++++
 tb/tb_vending_ctrl_multi.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/vending_ctrl_multi.sv
// vending_ctrl_multi
// Multi-product vending controller. Credit is kept in 5-taka units. A one-hot
// product select in IDLE latches that product's price. Coins are then collected,
// and any coin that would overfill the credit is rejected. Once the credit covers
// the price, the controller holds a vend request until the dispenser acknowledges
// it. Any change is then paid out as one chg_pulse per unit. A cancel during
// collection refunds the whole credit through the same change path.
//
// Ports
//   clk         in   system clock, rising edge
//   rst         in   asynchronous active-high reset
//   sel         in   one-hot product select pulse (NUM_PROD bits)
//   coin_05     in   5-taka coin pulse (1 unit)
//   coin_10     in   10-taka coin pulse (2 units)
//   coin_20     in   20-taka coin pulse (4 units)
//   cancel      in   abort/refund pulse
//   vend_ack    in   dispenser accepted the vend
//   vend_req    out  vend request, held until vend_ack
//   vend_id     out  latched product index, valid while vend_req
//   credit      out  current credit in units
//   coin_reject out  1-cycle pulse, coin returned unaccepted
//   chg_pulse   out  1-cycle pulse per 5 taka of change
//   busy        out  high whenever the controller is not idle
module vending_ctrl_multi #(
    parameter int unsigned                  NUM_PROD    = 4,
    parameter int unsigned                  UNIT_W      = 5,
    parameter logic [NUM_PROD*UNIT_W-1:0]   PRICE_TABLE = {5'd4, 5'd3, 5'd2, 5'd2},
    parameter int unsigned                  MAX_CREDIT  = 12,
    localparam int unsigned                 IDX_W       = (NUM_PROD > 1) ? $clog2(NUM_PROD) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_PROD-1:0] sel,
    input  logic                coin_05,
    input  logic                coin_10,
    input  logic                coin_20,
    input  logic                cancel,
    input  logic                vend_ack,
    output logic                vend_req,
    output logic [IDX_W-1:0]    vend_id,
    output logic [UNIT_W-1:0]   credit,
    output logic                coin_reject,
    output logic                chg_pulse,
    output logic                busy
);

    localparam logic [NUM_PROD-1:0] SelOne    = NUM_PROD'(1);
    localparam logic [UNIT_W-1:0]   MaxCredit = UNIT_W'(MAX_CREDIT);

    typedef enum logic [1:0] {
        StIdle,
        StCollect,
        StVend,
        StChange
    } state_e;

    state_e              state_q, state_d;
    logic [UNIT_W-1:0]   credit_q, credit_d;
    logic [UNIT_W-1:0]   change_q, change_d;
    logic [UNIT_W-1:0]   price_q, price_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic                phase_q, phase_d;      // 1 while chg_pulse is in its high phase
    logic                vend_req_q, vend_req_d;
    logic [IDX_W-1:0]    vend_id_q, vend_id_d;
    logic                coin_reject_q, coin_reject_d;
    logic                chg_pulse_q, chg_pulse_d;
    logic                busy_q, busy_d;

    logic                sel_onehot;
    logic [IDX_W-1:0]    sel_idx;
    logic [UNIT_W-1:0]   sel_price;
    logic                coin_any;
    logic                coin_multi;
    logic [UNIT_W-1:0]   coin_val;
    logic [UNIT_W-1:0]   credit_sum;
    logic                credit_fits;
    logic [UNIT_W-1:0]   vend_change;

    // Select decode: index and price of the single set bit.
    always_comb begin
        sel_onehot = (sel != '0) && ((sel & (sel - SelOne)) == '0);
        sel_idx    = '0;
        sel_price  = '0;
        for (int i = 0; i < int'(NUM_PROD); i++) begin
            if (sel[i]) begin
                sel_idx   = IDX_W'(i);
                sel_price = PRICE_TABLE[i*UNIT_W +: UNIT_W];
            end
        end
    end

    // Coin decode. MAX_CREDIT + 4 fits in UNIT_W, so credit_sum cannot wrap.
    always_comb begin
        coin_any    = coin_05 | coin_10 | coin_20;
        coin_multi  = (coin_05 & coin_10) | (coin_05 & coin_20) | (coin_10 & coin_20);
        coin_val    = coin_05 ? UNIT_W'(1) :
                      coin_10 ? UNIT_W'(2) :
                      coin_20 ? UNIT_W'(4) : '0;
        credit_sum  = credit_q + coin_val;
        credit_fits = (credit_sum <= MaxCredit);
        vend_change = credit_q - price_q;
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d       = state_q;
        credit_d      = credit_q;
        change_d      = change_q;
        price_d       = price_q;
        idx_d         = idx_q;
        phase_d       = phase_q;
        coin_reject_d = 1'b0;
        chg_pulse_d   = 1'b0;

        unique case (state_q)
            StIdle: begin
                coin_reject_d = coin_any;
                if (sel_onehot) begin
                    idx_d   = sel_idx;
                    price_d = sel_price;
                    state_d = StCollect;
                end
            end

            StCollect: begin
                if (cancel) begin
                    // Cancel wins over a vend that would start this cycle.
                    coin_reject_d = coin_any;
                    if (credit_q == '0) begin
                        state_d = StIdle;
                    end else begin
                        change_d = credit_q;
                        credit_d = '0;
                        phase_d  = 1'b0;
                        state_d  = StChange;
                    end
                end else begin
                    if (coin_any) begin
                        if (!coin_multi && credit_fits) begin
                            credit_d = credit_sum;
                        end else begin
                            coin_reject_d = 1'b1;
                        end
                    end
                    if (credit_q >= price_q) begin
                        state_d = StVend;
                    end
                end
            end

            StVend: begin
                coin_reject_d = coin_any;
                if (vend_ack) begin
                    change_d = vend_change;
                    credit_d = '0;
                    phase_d  = 1'b0;
                    state_d  = (vend_change != '0) ? StChange : StIdle;
                end
            end

            StChange: begin
                coin_reject_d = coin_any;
                if (phase_q) begin
                    phase_d = 1'b0;
                end else if (change_q == '0) begin
                    state_d = StIdle;
                end else begin
                    chg_pulse_d = 1'b1;
                    change_d    = change_q - UNIT_W'(1);
                    phase_d     = 1'b1;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase

        vend_req_d = (state_d == StVend);
        vend_id_d  = vend_req_d ? idx_d : '0;
        busy_d     = (state_d != StIdle);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= StIdle;
            credit_q      <= '0;
            change_q      <= '0;
            price_q       <= '0;
            idx_q         <= '0;
            phase_q       <= 1'b0;
            vend_req_q    <= 1'b0;
            vend_id_q     <= '0;
            coin_reject_q <= 1'b0;
            chg_pulse_q   <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            credit_q      <= credit_d;
            change_q      <= change_d;
            price_q       <= price_d;
            idx_q         <= idx_d;
            phase_q       <= phase_d;
            vend_req_q    <= vend_req_d;
            vend_id_q     <= vend_id_d;
            coin_reject_q <= coin_reject_d;
            chg_pulse_q   <= chg_pulse_d;
            busy_q        <= busy_d;
        end
    end

    assign vend_req    = vend_req_q;
    assign vend_id     = vend_id_q;
    assign credit      = credit_q;
    assign coin_reject = coin_reject_q;
    assign chg_pulse   = chg_pulse_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_vending_ctrl_multi.sv
// tb_vending_ctrl_multi
// Directed bench for vending_ctrl_multi. Products 0, 1 and 3 keep their default
// prices (2, 2 and 4 units). Product 2 is priced at 14 units, above the credit
// ceiling, so credit can be driven up to the overflow boundary without a vend.
module tb_vending_ctrl_multi;

    logic       clk;
    logic       rst;
    logic [3:0] sel;
    logic       coin_05;
    logic       coin_10;
    logic       coin_20;
    logic       cancel;
    logic       vend_ack;
    logic       vend_req;
    logic [1:0] vend_id;
    logic [4:0] credit;
    logic       coin_reject;
    logic       chg_pulse;
    logic       busy;

    int tests_run    = 0;
    int tests_failed = 0;

    vending_ctrl_multi #(
        .NUM_PROD    (4),
        .UNIT_W      (5),
        .PRICE_TABLE ({5'd4, 5'd14, 5'd2, 5'd2}),
        .MAX_CREDIT  (12)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .sel         (sel),
        .coin_05     (coin_05),
        .coin_10     (coin_10),
        .coin_20     (coin_20),
        .cancel      (cancel),
        .vend_ack    (vend_ack),
        .vend_req    (vend_req),
        .vend_id     (vend_id),
        .credit      (credit),
        .coin_reject (coin_reject),
        .chg_pulse   (chg_pulse),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] observed,
                         input logic [31:0] expected);
        tests_run++;
        assert (observed === expected) else begin
            tests_failed++;
            $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    initial begin
        int cnt;
        int first;
        int second;
        int vend_seen;
        int seen;

        rst = 1'b1; sel = '0; coin_05 = 0; coin_10 = 0; coin_20 = 0;
        cancel = 0; vend_ack = 0;
        tick();
        tick();
        check("rst_vend_req", vend_req, 0);
        check("rst_vend_id", vend_id, 0);
        check("rst_credit", credit, 0);
        check("rst_coin_reject", coin_reject, 0);
        check("rst_chg_pulse", chg_pulse, 0);
        check("rst_busy", busy, 0);
        rst = 1'b0;
        tick();

        // Coin in IDLE is rejected; an invalid select is ignored.
        coin_05 = 1; tick(); coin_05 = 0;
        check("idle_coin_reject", coin_reject, 1);
        check("idle_coin_credit", credit, 0);
        check("idle_coin_busy", busy, 0);
        tick();
        check("idle_reject_1cyc", coin_reject, 0);
        sel = 4'b0011; tick(); sel = '0;
        check("sel_two_bits_busy", busy, 0);
        tick();
        check("sel_two_bits_busy2", busy, 0);

        // Product 0 (2 units), exact payment, no change.
        sel = 4'b0001; tick(); sel = '0;
        check("p0_busy", busy, 1);
        check("p0_no_vend_yet", vend_req, 0);
        coin_10 = 1; tick(); coin_10 = 0;
        check("p0_credit", credit, 2);
        check("p0_coin_ok", coin_reject, 0);
        tick();
        check("p0_vend_req", vend_req, 1);
        check("p0_vend_id", vend_id, 0);
        coin_20 = 1; tick(); coin_20 = 0;
        check("vend_coin_reject", coin_reject, 1);
        check("vend_coin_credit", credit, 2);
        check("vend_req_held", vend_req, 1);
        vend_ack = 1; tick(); vend_ack = 0;
        check("p0_ack_vend_req", vend_req, 0);
        check("p0_ack_credit", credit, 0);
        check("p0_ack_busy", busy, 0);
        cnt = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (chg_pulse) cnt++;
        end
        check("p0_no_change", cnt, 0);

        // Product 3 (4 units), pays 5 units, one unit of change.
        sel = 4'b1000; tick(); sel = '0;
        coin_05 = 1; tick(); coin_05 = 0;
        check("p3_credit1", credit, 1);
        coin_20 = 1; tick(); coin_20 = 0;
        check("p3_credit5", credit, 5);
        tick();
        check("p3_vend_req", vend_req, 1);
        check("p3_vend_id", vend_id, 3);
        vend_ack = 1; tick(); vend_ack = 0;
        check("p3_ack_vend_req", vend_req, 0);
        check("p3_change_busy", busy, 1);
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (chg_pulse) cnt++;
        end
        check("p3_change_count", cnt, 1);
        check("p3_done_busy", busy, 0);

        // Product 1, two 5-taka coins then cancel before the vend starts.
        sel = 4'b0010; tick(); sel = '0;
        vend_seen = 0;
        coin_05 = 1; tick(); coin_05 = 0;
        if (vend_req) vend_seen = 1;
        check("p1_credit1", credit, 1);
        coin_05 = 1; tick(); coin_05 = 0;
        if (vend_req) vend_seen = 1;
        check("p1_credit2", credit, 2);
        cancel = 1; tick(); cancel = 0;
        if (vend_req) vend_seen = 1;
        check("p1_cancel_credit", credit, 0);
        check("p1_cancel_busy", busy, 1);
        cnt = 0; first = -1; second = -1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (vend_req) vend_seen = 1;
            if (chg_pulse) begin
                cnt++;
                if (first < 0) first = i;
                else if (second < 0) second = i;
            end
        end
        check("p1_refund_count", cnt, 2);
        check("p1_refund_spacing", second - first, 2);
        check("p1_never_vend", vend_seen, 0);
        check("p1_done_busy", busy, 0);

        // Product 2 (above ceiling): overflow and multi-coin rejection.
        sel = 4'b0100; tick(); sel = '0;
        coin_20 = 1; tick(); coin_20 = 0;
        coin_20 = 1; tick(); coin_20 = 0;
        coin_10 = 1; tick(); coin_10 = 0;
        check("p2_credit10", credit, 10);
        coin_20 = 1; tick(); coin_20 = 0;
        check("ovf_reject", coin_reject, 1);
        check("ovf_credit", credit, 10);
        coin_05 = 1; coin_10 = 1; tick(); coin_05 = 0; coin_10 = 0;
        check("multi_reject", coin_reject, 1);
        check("multi_credit", credit, 10);
        coin_05 = 1; tick();
        check("p2_credit11", credit, 11);
        tick();
        check("p2_credit12", credit, 12);
        tick(); coin_05 = 0;
        check("ceiling_reject", coin_reject, 1);
        check("ceiling_credit", credit, 12);
        check("p2_no_vend", vend_req, 0);

        // Cancel with a coin in the same cycle, then reset mid-refund.
        cancel = 1; coin_05 = 1; tick(); cancel = 0; coin_05 = 0;
        check("cancel_coin_reject", coin_reject, 1);
        check("cancel_credit", credit, 0);
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (chg_pulse) begin
                seen = 1;
                break;
            end
        end
        check("refund_first_pulse", seen, 1);
        rst = 1'b1;
        #1;
        check("async_rst_chg_pulse", chg_pulse, 0);
        check("async_rst_busy", busy, 0);
        check("async_rst_credit", credit, 0);
        check("async_rst_vend_req", vend_req, 0);
        tick();
        rst = 1'b0;
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (chg_pulse) cnt++;
        end
        check("post_rst_no_change", cnt, 0);
        check("post_rst_busy", busy, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
